// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the double-dabble display controller
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  typedef enum logic [1:0] {
    SEL_ONES,
    SEL_TENS,
    SEL_HUNDREDS
  } sel_t;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam int         BCD_DIGITS  = 3;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3_nibble.sv
// rtl/bcd_add3_nibble.sv - combinational add-3 correction for one BCD nibble
module bcd_add3_nibble
  import bcd_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= ADD3_THRESH) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/bcd_convert_ctrl.sv
// rtl/bcd_convert_ctrl.sv - iterative binary-to-BCD converter with 3-digit display scan
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits on the display.
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] bin_in,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [3:0]    hundreds,
  output logic [3:0]    tens,
  output logic [3:0]    ones,
  output logic [3:0]    an,
  output logic [3:0]    digit
);

  localparam int CW  = $clog2(DW + 1);
  localparam int SCW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t          state;
  logic [DW-1:0]   bin_sr;
  logic [11:0]     scratch;
  logic [11:0]     corr;
  logic [11:0]     next_scratch;
  logic [CW-1:0]   cnt;
  logic [SCW-1:0]  scan_cnt;
  sel_t            sel;

  bcd_add3_nibble u_add3_ones     (.nib_in(scratch[3:0]),  .nib_out(corr[3:0]));
  bcd_add3_nibble u_add3_tens     (.nib_in(scratch[7:4]),  .nib_out(corr[7:4]));
  bcd_add3_nibble u_add3_hundreds (.nib_in(scratch[11:8]), .nib_out(corr[11:8]));

  // Correct first, then shift the MSB of the binary operand into the BCD scratch.
  assign next_scratch = {corr[10:0], bin_sr[DW-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hundreds <= 4'd0;
      tens     <= 4'd0;
      ones     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin_in;
            scratch <= '0;
            cnt     <= CW'(DW);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          bin_sr  <= {bin_sr[DW-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          // The last shift lands the result directly in the output registers so
          // done and the new digits appear together in the FINISH cycle.
          if (cnt == CW'(1)) begin
            hundreds <= next_scratch[11:8];
            tens     <= next_scratch[7:4];
            ones     <= next_scratch[3:0];
            done     <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      sel      <= SEL_ONES;
    end else if (scan_cnt == SCW'(REFRESH_DIV - 1)) begin
      scan_cnt <= '0;
      if (sel == sel_t'(2'(BCD_DIGITS - 1)))
        sel <= SEL_ONES;
      else
        sel <= sel_t'(sel + 2'd1);
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    an    = 4'b1110;
    digit = ones;
    case (sel)
      SEL_TENS: begin
        an    = 4'b1101;
        digit = tens;
      end
      SEL_HUNDREDS: begin
        an    = 4'b1011;
        digit = hundreds;
      end
      default: begin
        an    = 4'b1110;
        digit = ones;
      end
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if ((sel == SEL_HUNDREDS && hundreds == 4'd0) ||
        (sel == SEL_TENS && hundreds == 4'd0 && tens == 4'd0)) begin
      an    = 4'b1111;
      digit = BCD_BLANK;
    end
`else
    if (sel == SEL_HUNDREDS && hundreds == BCD_BLANK) begin
      an    = 4'b1111;
      digit = BCD_BLANK;
    end
`endif
  end

endmodule
